// File: rtl/bram_cfg_dp.sv
// ---------------------------------------------------------------------------
// bram_cfg_dp
// Simple-dual-port block RAM with runtime-selectable port widths.
//
// The word is divided into 8 segments of DATA_WIDTH/8 bits. A segment is the
// smallest lane (mode 11). Mode k lanes span 8>>k segments, so every write is
// a set of segment write enables. There is no read-modify-write.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset of all output/pipeline state
//   wr_en      in   write request
//   wr_addr    in   {word address, sub-word select[2:0]}
//   wr_data    in   write data, lane value taken from the LSBs
//   wr_width   in   00 = W, 01 = W/2, 10 = W/4, 11 = W/8
//   always_we  in   write every cycle regardless of wr_en
//   rd_en      in   read request
//   rd_addr    in   {word address, sub-word select[2:0]}
//   rd_width   in   read lane width, same encoding as wr_width
//   out_reg    in   1 = two-cycle read latency, 0 = one-cycle
//   rd_data    out  selected lane, zero-extended, held between reads
//   rd_valid   out  one-cycle pulse per returned read
// ---------------------------------------------------------------------------
module bram_cfg_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH+2:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH+2:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic [1:0]              wr_width,
    input  logic [1:0]              rd_width,
    input  logic                    always_we,
    input  logic                    out_reg
);

    localparam int SEG_W = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Sub-word select bits that pick the lane in a given mode; the remaining
    // select bits address segments inside the lane.
    function automatic logic [2:0] lane_mask(input logic [1:0] mode);
        logic [2:0] m;
        case (mode)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b100;
            2'd2:    m = 3'b110;
            2'd3:    m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Move the lane starting at segment 'start' down to the LSBs and clear
    // everything above the lane width.
    function automatic logic [DATA_WIDTH-1:0] lane_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            mode,
        input logic [2:0]            start
    );
        logic [DATA_WIDTH-1:0] len_mask;
        len_mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (DATA_WIDTH >> mode));
        return (word >> (int'(start) * SEG_W)) & len_mask;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_we;
    logic [2:0]            w_wr_lmask;
    logic [ADDR_WIDTH-1:0] w_wr_word;
    logic [ADDR_WIDTH-1:0] w_rd_word;
    logic [7:0]            w_seg_we;
    logic [DATA_WIDTH-1:0] w_wr_rep;
    logic [DATA_WIDTH-1:0] w_rd_word_data;
    logic [DATA_WIDTH-1:0] w_ext;

    // Stage 1: fetched word plus the read configuration captured at issue.
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_word1;
    logic [1:0]            r_mode1;
    logic [2:0]            r_start1;
    logic                  r_oreg1;
    // Stage 2: extracted lane waiting for the extra output register.
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_data2;

    // Writes are held off while reset is asserted.
    assign w_we       = (wr_en | always_we) & ~rst;
    assign w_wr_lmask = lane_mask(wr_width);
    assign w_wr_word  = wr_addr[ADDR_WIDTH+2:3];
    assign w_rd_word  = rd_addr[ADDR_WIDTH+2:3];

    // Segment write enables and lane data replicated into every lane position.
    always_comb begin
        w_seg_we = 8'h00;
        w_wr_rep = '0;
        for (int s = 0; s < 8; s++) begin
            if (w_we && ((3'(s) & w_wr_lmask) == (wr_addr[2:0] & w_wr_lmask))) begin
                w_seg_we[s] = 1'b1;
            end else begin
                w_seg_we[s] = 1'b0;
            end
            w_wr_rep[s*SEG_W +: SEG_W] = wr_data[int'(3'(s) & ~w_wr_lmask)*SEG_W +: SEG_W];
        end
    end

    // Memory array: segment-granular writes, contents never reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 8; s++) begin
            if (w_seg_we[s]) begin
                r_mem[w_wr_word][s*SEG_W +: SEG_W] <= w_wr_rep[s*SEG_W +: SEG_W];
            end
        end
    end

    // Write-first read: segments being written to the same word this cycle
    // come from the write data, the rest from the array.
    always_comb begin
        w_rd_word_data = r_mem[w_rd_word];
        for (int s = 0; s < 8; s++) begin
            if ((w_wr_word == w_rd_word) && w_seg_we[s]) begin
                w_rd_word_data[s*SEG_W +: SEG_W] = w_wr_rep[s*SEG_W +: SEG_W];
            end else begin
                w_rd_word_data[s*SEG_W +: SEG_W] = r_mem[w_rd_word][s*SEG_W +: SEG_W];
            end
        end
    end

    // Stage 1 register: capture word and read configuration at issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_word1  <= '0;
            r_mode1  <= 2'd0;
            r_start1 <= 3'd0;
            r_oreg1  <= 1'b0;
        end else begin
            r_v1 <= rd_en;
            if (rd_en) begin
                r_word1  <= w_rd_word_data;
                r_mode1  <= rd_width;
                r_start1 <= rd_addr[2:0] & lane_mask(rd_width);
                r_oreg1  <= out_reg;
            end
        end
    end

    assign w_ext = lane_extract(r_word1, r_mode1, r_start1);

    // Stage 2 register: holds results of reads issued with out_reg = 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_data2 <= '0;
        end else begin
            r_v2 <= r_v1 & r_oreg1;
            if (r_v1 && r_oreg1) begin
                r_data2 <= w_ext;
            end
        end
    end

    // Output register. A latency-1 result landing together with a latency-2
    // result (out_reg switched 1->0) wins; the older one is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (r_v1 && !r_oreg1) begin
            rd_data  <= w_ext;
            rd_valid <= 1'b1;
        end else if (r_v2) begin
            rd_data  <= r_data2;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_cfg_dp.sv
// ---------------------------------------------------------------------------
// tb_bram_cfg_dp
// Randomised and directed stimulus for bram_cfg_dp. The reference model keeps
// the memory as an array of words with lane writes done by mask arithmetic.
// Reads are kept as a queue of {due edge, value}. On every falling edge the
// DUT outputs are compared with the model. Directed cases also check literal
// values computed by hand.
// ---------------------------------------------------------------------------
module tb_bram_cfg_dp;

    localparam int DW = 32;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW+2:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            rd_en;
    logic [AW+2:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic [1:0]      wr_width;
    logic [1:0]      rd_width;
    logic            always_we;
    logic            out_reg;

    bram_cfg_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_width(wr_width), .rd_width(rd_width),
        .always_we(always_we), .out_reg(out_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] mem_model [1 << AW];
    rd_t         q[$];
    int          edge_n = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = 32'h0;
    int          errors = 0;
    int          checks = 0;
    logic        running = 1'b1;

    function automatic logic [31:0] model_read(input logic [AW+2:0] a, input logic [1:0] k);
        int lw, lane;
        longint unsigned mask, v;
        lw   = DW >> k;
        lane = int'(a[2:0]) >> (3 - int'(k));
        mask = (64'd1 << lw) - 64'd1;
        v    = 64'(mem_model[a[AW+2:3]]);
        return 32'((v >> (lane * lw)) & mask);
    endfunction

    task automatic model_write(input logic [AW+2:0] a, input logic [1:0] k, input logic [31:0] d);
        int lw, lane;
        longint unsigned mask, v;
        lw   = DW >> k;
        lane = int'(a[2:0]) >> (3 - int'(k));
        mask = (64'd1 << lw) - 64'd1;
        v    = 64'(mem_model[a[AW+2:3]]);
        v    = (v & ~(mask << (lane * lw))) | ((64'(d) & mask) << (lane * lw));
        mem_model[a[AW+2:3]] = v[31:0];
    endtask

    // One clock edge: model the edge from the current inputs, then wait for it.
    task automatic tick();
        logic        hit;
        logic [31:0] d;
        rd_t         keep[$];
        edge_n++;
        hit = 1'b0;
        d   = exp_data;
        if (!rst) begin
            foreach (q[i]) begin
                if (q[i].due == edge_n) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end else begin
                    keep.push_back(q[i]);
                end
            end
            q = keep;
            if (wr_en || always_we) model_write(wr_addr, wr_width, wr_data);
            if (rd_en) q.push_back('{edge_n + (out_reg ? 2 : 1), model_read(rd_addr, rd_width)});
        end
        @(posedge clk);
        if (!rst) begin
            exp_valid = hit;
            exp_data  = d;
        end
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic reset_on();
        rst = 1'b1;
        q.delete();
        exp_valid = 1'b0;
        exp_data  = 32'h0;
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; always_we = 1'b0;
    endtask

    task automatic set_wr(input int word, input int sel, input logic [1:0] k, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = {8'(word), 3'(sel)}; wr_width = k; wr_data = d;
    endtask

    task automatic set_rd(input int word, input int sel, input logic [1:0] k, input logic o);
        rd_en = 1'b1; rd_addr = {8'(word), 3'(sel)}; rd_width = k; out_reg = o;
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        while (running) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== exp_valid) begin
                errors++;
                $display("FAIL cycle_valid edge %0d: got %b expected %b", edge_n, rd_valid, exp_valid);
            end
            checks++;
            if (rd_data !== exp_data) begin
                errors++;
                $display("FAIL cycle_data edge %0d: got %h expected %h", edge_n, rd_data, exp_data);
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; always_we = 1'b0; out_reg = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_width = 2'd0; rd_width = 2'd0;
        tick(); tick();
        check("reset_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_data", rd_data, 32'd0);
        rst = 1'b0;

        // Fill every word with its own index using always_we.
        for (int i = 0; i < (1 << AW); i++) begin
            idle(); always_we = 1'b1;
            wr_addr = {8'(i), 3'b000}; wr_width = 2'd0; wr_data = 32'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            set_rd(i, 0, 2'd0, 1'b0); tick(); idle(); tick();
            check("always_we_readback", rd_data, 32'(i));
        end

        // Full-width round trip, latency 1 then latency 2.
        set_wr(5, 0, 2'd0, 32'hDEADBEEF); tick(); idle();
        set_rd(5, 0, 2'd0, 1'b0); tick(); idle();
        check("rt_lat1_early", {31'd0, rd_valid}, 32'd0);
        tick();
        check("rt_lat1_valid", {31'd0, rd_valid}, 32'd1);
        check("rt_lat1_data", rd_data, 32'hDEADBEEF);
        tick();
        set_rd(5, 0, 2'd0, 1'b1); tick(); idle(); tick();
        check("rt_lat2_early", {31'd0, rd_valid}, 32'd0);
        tick();
        check("rt_lat2_valid", {31'd0, rd_valid}, 32'd1);
        check("rt_lat2_data", rd_data, 32'hDEADBEEF);

        // Byte writes into word 3, then wide and nibble reads.
        set_wr(3, 0, 2'd2, 32'h11); tick();
        set_wr(3, 2, 2'd2, 32'h22); tick();
        set_wr(3, 4, 2'd2, 32'h33); tick();
        set_wr(3, 6, 2'd2, 32'h44); tick(); idle();
        set_rd(3, 0, 2'd0, 1'b0); tick(); idle(); tick();
        check("narrow_wr_wide_rd", rd_data, 32'h44332211);
        set_rd(3, 3, 2'd3, 1'b0); tick(); idle(); tick();
        check("nibble_rd", rd_data, 32'h00000002);

        // Read width changed while a latency-2 read is in flight.
        set_rd(3, 2, 2'd2, 1'b1); tick(); idle(); rd_width = 2'd0; tick(); tick();
        check("mode_change_valid", {31'd0, rd_valid}, 32'd1);
        check("mode_change_data", rd_data, 32'h00000022);

        // Same-word collision is write-first.
        set_wr(7, 0, 2'd0, 32'hAAAAAAAA); tick(); idle();
        set_wr(7, 4, 2'd1, 32'h1234); set_rd(7, 0, 2'd0, 1'b0); tick(); idle(); tick();
        check("collision", rd_data, 32'h1234AAAA);

        // out_reg 1 -> 0: both land together, the later read wins, one pulse.
        set_rd(5, 0, 2'd0, 1'b1); tick();
        set_rd(3, 0, 2'd0, 1'b0); tick(); idle(); tick();
        check("switch_valid", {31'd0, rd_valid}, 32'd1);
        check("switch_data", rd_data, 32'h44332211);
        tick();
        check("switch_single_pulse", {31'd0, rd_valid}, 32'd0);

        // Reset while a latency-2 read is in flight; writes blocked in reset.
        set_rd(5, 0, 2'd0, 1'b1); tick(); idle();
        reset_on();
        check("rst_async_data", rd_data, 32'd0);
        check("rst_async_valid", {31'd0, rd_valid}, 32'd0);
        set_wr(16, 0, 2'd0, 32'hBAD0BAD0); tick(); tick(); idle();
        rst = 1'b0;
        set_rd(16, 0, 2'd0, 1'b0); tick(); idle(); tick();
        check("rst_write_blocked", rd_data, 32'h00000010);

        // Random traffic over a small word range to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            always_we = ($urandom_range(0, 15) == 0);
            wr_addr   = {8'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            wr_width  = 2'($urandom_range(0, 3));
            wr_data   = $urandom;
            rd_en     = 1'($urandom_range(0, 1));
            rd_addr   = {8'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            rd_width  = 2'($urandom_range(0, 3));
            out_reg   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                reset_on();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        idle();
        tick(); tick(); tick();

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
